// File: rtl/canny_accel_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : canny_accel_mul_pkg
//  Purpose  : Shared constants for the canny_accel_mul pipelined multiplier:
//             legal pipeline depth range, operand-mode and accumulate-mode
//             encodings, and a small constant helper used for width sizing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package canny_accel_mul_pkg;

    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 8;

    // Operand interpretation (SIGNED parameter)
    localparam int MODE_UNSIGNED = 0;
    localparam int MODE_SIGNED   = 1;

    // Result mode (ACC parameter)
    localparam int ACC_OFF = 0;
    localparam int ACC_ON  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : canny_accel_mul_pkg
`default_nettype wire

// File: rtl/canny_accel_mul_dly.sv
`default_nettype none
// ============================================================================
//  Module   : canny_accel_mul_dly
//  Purpose  : ce-gated, reset-cleared delay line for the valid and
//             accumulator-clear side-band bits. The first stage samples the
//             inputs; a clear bit is only kept when its beat is valid.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset (clears every stage)
//             ce     - advance enable; all stages hold when low
//             i_vld  - valid bit entering the line
//             i_clr  - clear bit entering the line
//             o_vld  - valid bit after DEPTH enabled edges
//             o_clr  - clear bit after DEPTH enabled edges
//  Revision : 1.0 - initial release
// ============================================================================
module canny_accel_mul_dly
    import canny_accel_mul_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic i_vld,
    input  logic i_clr,
    output logic o_vld,
    output logic o_clr
);

    if (DEPTH < 1 || DEPTH > NUM_STAGE_MAX - 1) begin : g_bad_depth
        $error("canny_accel_mul_dly: DEPTH %0d out of range", DEPTH);
    end

    logic [DEPTH-1:0] r_vld_q, r_vld_d;
    logic [DEPTH-1:0] r_clr_q, r_clr_d;

    always_comb begin
        r_vld_d = r_vld_q;
        r_clr_d = r_clr_q;
        if (ce) begin
            r_vld_d[0] = i_vld;
            // A clear riding on an idle beat must never reach the accumulator.
            r_clr_d[0] = i_clr & i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld_d[i] = r_vld_q[i-1];
                r_clr_d[i] = r_clr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_q <= '0;
            r_clr_q <= '0;
        end else begin
            r_vld_q <= r_vld_d;
            r_clr_q <= r_clr_d;
        end
    end

    assign o_vld = r_vld_q[DEPTH-1];
    assign o_clr = r_clr_q[DEPTH-1];

endmodule : canny_accel_mul_dly
`default_nettype wire

// File: rtl/canny_accel_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : canny_accel_mul_pipe
//  Purpose  : NUM_STAGE-deep pipelined multiplier with optional
//             multiply-accumulate. Stage 1 registers operands, stage 2 forms
//             the full product, later stages delay it and the last stage
//             narrows / accumulates into dout.
//  Macro    : CANNY_ACCEL_MUL_SAT_EN - when defined, narrowing and
//             accumulation saturate to the dout range; otherwise the low
//             dout_WIDTH bits are kept (accumulation wraps).
//  Ports    : clk      - clock, rising edge
//             reset    - synchronous active-high reset, overrides ce
//             ce       - pipeline advance enable
//             din_vld  - din0/din1/acc_clr carry a valid beat
//             din0     - operand A [din0_WIDTH]
//             din1     - operand B [din1_WIDTH]
//             acc_clr  - ACC=1: this beat starts a new sum
//             dout_vld - dout carries a valid result
//             dout     - product or running sum [dout_WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
module canny_accel_mul_pipe
    import canny_accel_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 4,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 30,
    parameter int SIGNED     = MODE_UNSIGNED,
    parameter int ACC        = ACC_OFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_vld,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    output logic                  dout_vld,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int P  = din0_WIDTH + din1_WIDTH;
    // Two guard bits so acc + product can never overflow the working width.
    localparam int W  = max_int(P, dout_WIDTH) + 2;
    localparam int PD = NUM_STAGE - 2;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
        $error("canny_accel_mul_pipe: NUM_STAGE %0d outside %0d..%0d",
               NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
    end

    // ------------------------------------------------------------------
    // Stage 1: operand registers (side-band bits live in the delay line)
    // ------------------------------------------------------------------
    logic [din0_WIDTH-1:0] r_a_q, r_a_d;
    logic [din1_WIDTH-1:0] r_b_q, r_b_d;

    always_comb begin
        r_a_d = r_a_q;
        r_b_d = r_b_q;
        if (ce) begin
            r_a_d = din0;
            r_b_d = din1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            r_a_q <= r_a_d;
            r_b_q <= r_b_d;
        end
    end

    // Valid/clear travel NUM_STAGE-1 edges so they line up with the product
    // presented to the final stage.
    logic w_vld_s;
    logic w_clr_s;

    canny_accel_mul_dly #(
        .DEPTH (NUM_STAGE - 1)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .i_vld (din_vld),
        .i_clr (acc_clr),
        .o_vld (w_vld_s),
        .o_clr (w_clr_s)
    );

    // ------------------------------------------------------------------
    // Stage 2: full-width product. Extending both operands to P bits makes
    // the low P bits of one multiplier correct for either signedness.
    // ------------------------------------------------------------------
    logic         w_sa, w_sb;
    logic [P-1:0] w_a_ext, w_b_ext, w_prod, w_prod_s;

    assign w_sa    = (SIGNED != MODE_UNSIGNED) && r_a_q[din0_WIDTH-1];
    assign w_sb    = (SIGNED != MODE_UNSIGNED) && r_b_q[din1_WIDTH-1];
    assign w_a_ext = {{din1_WIDTH{w_sa}}, r_a_q};
    assign w_b_ext = {{din0_WIDTH{w_sb}}, r_b_q};
    assign w_prod  = w_a_ext * w_b_ext;

    // Stages 2..NUM_STAGE-1 hold the product; the final stage is dout itself.
    if (PD > 0) begin : g_pdly
        logic [P-1:0] r_pd_q [PD];
        logic [P-1:0] r_pd_d [PD];

        always_comb begin
            r_pd_d = r_pd_q;
            if (ce) begin
                r_pd_d[0] = w_prod;
                for (int i = 1; i < PD; i++) begin
                    r_pd_d[i] = r_pd_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PD; i++) begin
                    r_pd_q[i] <= '0;
                end
            end else begin
                r_pd_q <= r_pd_d;
            end
        end

        assign w_prod_s = r_pd_q[PD-1];
    end else begin : g_pdirect
        assign w_prod_s = w_prod;
    end

    // ------------------------------------------------------------------
    // Final stage: narrow / accumulate. In ACC mode dout doubles as the
    // accumulator, so an idle beat simply holds the running sum.
    // ------------------------------------------------------------------
    logic [dout_WIDTH-1:0] r_dout_q, r_dout_d;
    logic                  r_vld_q, r_vld_d;
    logic [W-1:0]          w_prod_ext, w_acc_ext, w_base, w_sum;
    logic [dout_WIDTH-1:0] w_res;

    assign w_prod_ext = {{(W-P){(SIGNED != MODE_UNSIGNED) && w_prod_s[P-1]}}, w_prod_s};
    assign w_acc_ext  = {{(W-dout_WIDTH){(SIGNED != MODE_UNSIGNED) && r_dout_q[dout_WIDTH-1]}},
                         r_dout_q};
    assign w_base     = ((ACC != ACC_OFF) && !w_clr_s) ? w_acc_ext : '0;
    assign w_sum      = w_base + w_prod_ext;

`ifdef CANNY_ACCEL_MUL_SAT_EN
    localparam logic [W-1:0] c_UMAX = {{(W-dout_WIDTH){1'b0}}, {dout_WIDTH{1'b1}}};
    localparam logic [W-1:0] c_SMAX = {{(W-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [W-1:0] c_SMIN = {{(W-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

    always_comb begin
        w_res = w_sum[dout_WIDTH-1:0];
        if (SIGNED != MODE_UNSIGNED) begin
            if ($signed(w_sum) > $signed(c_SMAX)) begin
                w_res = c_SMAX[dout_WIDTH-1:0];
            end else if ($signed(w_sum) < $signed(c_SMIN)) begin
                w_res = c_SMIN[dout_WIDTH-1:0];
            end
        end else if (w_sum > c_UMAX) begin
            // Unsigned sums are never negative, only the top needs clamping.
            w_res = c_UMAX[dout_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        w_res = w_sum[dout_WIDTH-1:0];
    end
`endif

    always_comb begin
        r_dout_d = r_dout_q;
        r_vld_d  = r_vld_q;
        if (ce) begin
            r_vld_d = w_vld_s;
            if (w_vld_s) begin
                r_dout_d = w_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_q <= '0;
            r_vld_q  <= 1'b0;
        end else begin
            r_dout_q <= r_dout_d;
            r_vld_q  <= r_vld_d;
        end
    end

    assign dout     = r_dout_q;
    assign dout_vld = r_vld_q;

    // Guard bits of the working sum are only read when saturating.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_sum, (ID != 0)};

endmodule : canny_accel_mul_pipe
`default_nettype wire

// File: doc/canny_accel_mul_pipe.md
CANNY_ACCEL_MUL_PIPE -- requirements
Module: canny_accel_mul_pipe

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ID, 1, instance tag, no functional effect
  NUM_STAGE, 4, latency in ce-enabled cycles, legal 2..8
  din0_WIDTH, 16, operand A width
  din1_WIDTH, 15, operand B width
  dout_WIDTH, 30, result and accumulator width
  SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
  ACC, 0, 0 = multiply only, 1 = multiply-accumulate
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock, all logic on its rising edge
  reset  in  1  synchronous, active-high reset
  ce  in  1  pipeline advance enable
  din_vld  in  1  din0/din1/acc_clr carry a valid beat
  din0  in  din0_WIDTH  operand A
  din1  in  din1_WIDTH  operand B
  acc_clr  in  1  ACC=1: this beat starts a new sum
  dout_vld  out  1  dout carries a valid result
  dout  out  dout_WIDTH  product or running sum

Function
REQ-003 Stage 1 SHALL register din0, din1, din_vld and acc_clr; stage 2 SHALL form the full P = din0_WIDTH+din1_WIDTH bit product; stages 3..NUM_STAGE SHALL delay it, with the ACC update in the last stage.
REQ-004 A beat sampled at a ce=1 edge SHALL appear on dout/dout_vld after exactly NUM_STAGE ce=1 edges; ce=0 cycles SHALL not count.
REQ-005 With ce=0, every register, including the valid and clear pipelines and the accumulator, SHALL hold its value.
REQ-006 din_vld=0 beats SHALL still advance the pipeline, give dout_vld=0 and leave the accumulator unchanged. dout is don't-care when dout_vld=0.
REQ-007 SIGNED=1 SHALL use a signed product. SIGNED=0 SHALL use an unsigned product.
REQ-008 If dout_WIDTH > P, the product SHALL be sign-extended (SIGNED=1) or zero-extended (SIGNED=0).
REQ-009 If dout_WIDTH < P, the handling is set by REQ-017.
REQ-010 ACC=1 SHALL work as follows:
  on a valid final-stage beat, acc <= (acc_clr of that beat ? 0 : acc) + product, then dout = acc
  acc_clr SHALL travel aligned with its operands
  acc_clr with din_vld=0 SHALL be ignored
REQ-011 ACC=0 SHALL leave acc_clr unused.
REQ-012 Illegal NUM_STAGE SHALL stop elaboration with an error.

Reset
REQ-013 reset=1 at a clock edge SHALL set dout=0, dout_vld=0, the accumulator to 0, and all valid and clear stages to 0.
REQ-014 reset SHALL override ce.
REQ-015 Beats in flight at reset SHALL be discarded.
REQ-016 The first beat accepted after reset deasserts SHALL emerge after NUM_STAGE ce=1 edges.

Configuration
REQ-017 Macro CANNY_ACCEL_MUL_SAT_EN SHALL select narrowing and overflow behaviour:
  defined: narrowing and accumulation SHALL saturate to the dout_WIDTH range (unsigned max 2^dout_WIDTH-1; signed -2^(dout_WIDTH-1)..2^(dout_WIDTH-1)-1)
  undefined: narrowing SHALL keep the low dout_WIDTH bits, and accumulation SHALL wrap modulo 2^dout_WIDTH

Structure
REQ-018 Shared package canny_accel_mul_pkg SHALL hold NUM_STAGE_MIN=2, NUM_STAGE_MAX=8 and the SIGNED/ACC mode constants.
REQ-019 Sub-module canny_accel_mul_dly SHALL implement the ce-gated, reset-cleared valid/clear delay line of parametric depth.
REQ-020 Implementation target: about 120-400 lines of RTL.

Verification
REQ-021 Default parameters, din0=65535, din1=32767, din_vld=1, ce=1:
  dout_vld=1 exactly 4 edges later
  without the macro: dout=1073643521
  with the macro: dout=1073741823
REQ-022 SIGNED=1, din0=16'hFFFD (-3), din1=5 -> dout = -15 sign-extended (30'h3FFFFFF1).
REQ-023 ACC=1, beats (2,3,clr=1), (4,5,0), (1,1,0) back-to-back -> dout 6, 26, 27 on consecutive valid outputs; an idle beat between them leaves the sum unchanged.
REQ-024 Stream 1,2,3 x 1 with ce=0 for 3 cycles after the second beat -> outputs stay frozen for 3 cycles; then 1,2,3 in order; no beat lost or duplicated.
REQ-025 reset pulsed with 3 beats in flight -> dout_vld=0 and dout=0 next edge; no stale beat emerges; a new beat emerges after NUM_STAGE edges.
REQ-026 NUM_STAGE=2 and NUM_STAGE=8 sweeps of random operands -> output matches the reference model at exact latency.
